// File: rtl/bus_master_arb_if.sv
// bus_master_arb_if: requester-side and bus-side signal bundle
// for the round-robin register-bus master.
interface bus_master_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      m_req;
  logic [NREQ-1:0]      m_we;
  logic [32*NREQ-1:0]   m_addr;
  logic [32*NREQ-1:0]   m_wdata;
  logic [NREQ-1:0]      m_done;
  logic                 m_err;
  logic [31:0]          m_rdata;
  logic [31:0]          bus_addr;
  logic [31:0]          bus_wr_data;
  logic                 bus_rd_req;
  logic                 bus_wr_req;
  logic [31:0]          bus_rd_data;
  logic                 bus_rd_ack;
  logic                 bus_wr_ack;

  modport master (
    input  m_req,
    input  m_we,
    input  m_addr,
    input  m_wdata,
    output m_done,
    output m_err,
    output m_rdata,
    output bus_addr,
    output bus_wr_data,
    output bus_rd_req,
    output bus_wr_req,
    input  bus_rd_data,
    input  bus_rd_ack,
    input  bus_wr_ack
  );

  modport slave (
    output m_req,
    output m_we,
    output m_addr,
    output m_wdata,
    input  m_done,
    input  m_err,
    input  m_rdata,
    input  bus_addr,
    input  bus_wr_data,
    input  bus_rd_req,
    input  bus_wr_req,
    output bus_rd_data,
    output bus_rd_ack,
    output bus_wr_ack
  );
endinterface

// File: rtl/bus_master_arb.sv
// bus_master_arb: round-robin arbiter and single-transaction
// sequencer for the shared register bus, with ack timeout.
module bus_master_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input logic             bus_clk,
  input logic             bus_reset,
  bus_master_arb_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            we_q, we_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rd_req_q, rd_req_d;
  logic            wr_req_q, wr_req_d;

  logic [IW-1:0]   pick;
  logic            found;
  logic            ack_ok;

  // Round-robin search: first requester above the last grant, wrapping.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.m_req[IW'((int'(ptr_q) + k) % NREQ)]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Only the ack matching the latched direction completes a transaction.
  always_comb begin
    ack_ok = we_q ? bus.bus_wr_ack : bus.bus_rd_ack;
  end

  // Sequencer next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_req_d = 1'b0;
    wr_req_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d    = pick;
          ptr_d    = pick;
          we_d     = bus.m_we[pick];
          addr_d   = bus.m_addr[int'(pick)*32 +: 32];
          wdata_d  = bus.m_wdata[int'(pick)*32 +: 32];
          rd_req_d = ~bus.m_we[pick];
          wr_req_d = bus.m_we[pick];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (ack_ok) begin
          rdata_d       = we_q ? 32'h0 : bus.bus_rd_data;
          err_d         = 1'b0;
          done_d[gnt_q] = 1'b1;
          state_d       = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_ok) begin
          rdata_d       = we_q ? 32'h0 : bus.bus_rd_data;
          err_d         = 1'b0;
          done_d[gnt_q] = 1'b1;
          state_d       = S_DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rdata_d       = 32'h0;
          err_d         = 1'b1;
          done_d[gnt_q] = 1'b1;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; pointer resets so requester 0 wins first.
  always_ff @(posedge bus_clk or posedge bus_reset) begin
    if (bus_reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      ptr_q    <= IW'(NREQ - 1);
      we_q     <= 1'b0;
      cnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
    end
  end

  assign bus.m_done      = done_q;
  assign bus.m_err       = err_q;
  assign bus.m_rdata     = rdata_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wdata_q;
  assign bus.bus_rd_req  = rd_req_q;
  assign bus.bus_wr_req  = wr_req_q;

endmodule

// File: tb/tb_bus_master_arb.sv
// tb_bus_master_arb: directed scenarios for bus_master_arb with a
// registered ROM slave, a write-ack slave and ack injection.
module tb_bus_master_arb;

  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_master_arb_if #(.NREQ(NREQ)) intf ();

  bus_master_arb #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .bus_clk   (clk),
    .bus_reset (rst),
    .bus       (intf.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        rom_ack;
  logic [31:0] rom_data;
  logic        wsl_ack;
  logic [31:0] wsl_reg;
  logic        inj_rd_ack = 1'b0;
  logic [31:0] inj_rd_data = 32'h0;
  logic        inj_wr_ack = 1'b0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [5:0] w;
    w = a[7:2];
    return (w == 6'd4) ? 32'hCAFEF00D : {26'h0B0B0B0, w};
  endfunction

  // ROM at 0x1000, 256 bytes, registered read ack; writes never acked.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_ack  <= 1'b0;
      rom_data <= 32'h0;
    end else if (intf.bus_rd_req && intf.bus_addr[31:8] == 24'h000010) begin
      rom_ack  <= 1'b1;
      rom_data <= rom_word(intf.bus_addr);
    end else begin
      rom_ack  <= 1'b0;
      rom_data <= 32'h0;
    end
  end

  // Write slave at 0x2000 with registered write ack.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wsl_ack <= 1'b0;
      wsl_reg <= 32'h0;
    end else if (intf.bus_wr_req && intf.bus_addr[31:8] == 24'h000020) begin
      wsl_ack <= 1'b1;
      wsl_reg <= intf.bus_wr_data;
    end else begin
      wsl_ack <= 1'b0;
    end
  end

  assign intf.bus_rd_data = rom_data | inj_rd_data;
  assign intf.bus_rd_ack  = rom_ack | inj_rd_ack;
  assign intf.bus_wr_ack  = wsl_ack | inj_wr_ack;

  task automatic setup(input int i, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    intf.m_we[i]           = we;
    intf.m_addr[i*32 +: 32]  = a;
    intf.m_wdata[i*32 +: 32] = d;
  endtask

  // Runs one transaction from requester i; returns latency and m_done.
  task automatic do_txn(input int i, input logic we,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [3:0] dv);
    setup(i, we, a, d);
    intf.m_req[i] = 1'b1;
    lat = 0;
    dv  = 4'h0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      lat++;
      if (intf.m_done != 4'h0) begin
        dv = intf.m_done;
        break;
      end
    end
    intf.m_req[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (intf.m_done !== 4'h0 || intf.m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done_err: got %b/%b want 0000/0", intf.m_done, intf.m_err);
    end
    n_checks++;
    if (intf.m_rdata !== 32'h0 || intf.bus_addr !== 32'h0 || intf.bus_wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h want 0", intf.m_rdata, intf.bus_addr, intf.bus_wr_data);
    end
    n_checks++;
    if (intf.bus_rd_req !== 1'b0 || intf.bus_wr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b%b want 00", intf.bus_rd_req, intf.bus_wr_req);
    end
    rst = 1'b0;
  endtask

  task automatic test_rom_read();
    setup(1, 1'b0, 32'h1010, 32'h0);
    intf.m_req[1] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (intf.bus_rd_req !== 1'b1 || intf.bus_wr_req !== 1'b0 || intf.bus_addr !== 32'h1010) begin
      n_fail++;
      $display("FAIL rom_c1: rd %b wr %b addr %h want 1 0 00001010", intf.bus_rd_req, intf.bus_wr_req, intf.bus_addr);
    end
    @(negedge clk);
    n_checks++;
    if (intf.bus_rd_req !== 1'b0 || intf.m_done !== 4'h0) begin
      n_fail++;
      $display("FAIL rom_c2: rd %b done %b want 0 0000", intf.bus_rd_req, intf.m_done);
    end
    @(negedge clk);
    n_checks++;
    if (intf.m_done !== 4'b0010 || intf.m_rdata !== 32'hCAFEF00D || intf.m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rom_c3: done %b data %h err %b want 0010 cafef00d 0", intf.m_done, intf.m_rdata, intf.m_err);
    end
    intf.m_req[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (intf.m_done !== 4'h0 || intf.m_rdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL rom_c4: done %b data %h want 0000 cafef00d", intf.m_done, intf.m_rdata);
    end
  endtask

  task automatic test_arb_order();
    int exp_ord [7] = '{0, 2, 3, 0, 1, 2, 3};
    int got;
    int last_c;
    int g;
    for (int i = 0; i < NREQ; i++) setup(i, 1'b0, 32'h1010, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    intf.m_req = 4'b0101;
    @(negedge clk);
    rst = 1'b0;
    got = 0;
    last_c = 0;
    for (int c = 1; c <= 200 && got < 7; c++) begin
      @(negedge clk);
      if (intf.m_done != 4'h0) begin
        g = -1;
        for (int i = 0; i < NREQ; i++) if (intf.m_done[i]) g = i;
        n_checks++;
        if (g != exp_ord[got]) begin
          n_fail++;
          $display("FAIL arb_order[%0d]: got %0d want %0d", got, g, exp_ord[got]);
        end
        if (got >= 3) begin
          n_checks++;
          if (c - last_c != 4) begin
            n_fail++;
            $display("FAIL b2b_gap[%0d]: got %0d want 4", got, c - last_c);
          end
        end
        last_c = c;
        got++;
        if (got < 2) intf.m_req[g] = 1'b0;
        else if (got == 2) intf.m_req = 4'b1111;
        else if (got == 7) intf.m_req = 4'b0000;
      end
    end
    n_checks++;
    if (got != 7) begin
      n_fail++;
      $display("FAIL arb_count: got %0d want 7", got);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    logic [3:0] dv;
    logic bad;
    do_txn(3, 1'b0, 32'h8000, 32'h0, lat, dv);
    n_checks++;
    if (lat != TO + 2 || dv !== 4'b1000) begin
      n_fail++;
      $display("FAIL to_lat: lat %0d done %b want %0d 1000", lat, dv, TO + 2);
    end
    n_checks++;
    if (intf.m_err !== 1'b1 || intf.m_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL to_err: err %b data %h want 1 0", intf.m_err, intf.m_rdata);
    end
    @(negedge clk);
    inj_rd_ack  = 1'b1;
    inj_rd_data = 32'hDEADBEEF;
    @(negedge clk);
    inj_rd_ack  = 1'b0;
    inj_rd_data = 32'h0;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (intf.m_done !== 4'h0 || intf.bus_rd_req !== 1'b0 || intf.m_err !== 1'b1 || intf.m_rdata !== 32'h0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack: activity got %b want 0", bad);
    end
  endtask

  task automatic test_write();
    int lat;
    logic [3:0] dv;
    do_txn(0, 1'b1, 32'h1004, 32'h11112222, lat, dv);
    n_checks++;
    if (lat != TO + 2 || dv !== 4'b0001 || intf.m_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_rom: lat %0d done %b err %b want %0d 0001 1", lat, dv, intf.m_err, TO + 2);
    end
    do_txn(1, 1'b0, 32'h1010, 32'h0, lat, dv);
    n_checks++;
    if (lat != 3 || intf.m_rdata !== 32'hCAFEF00D || intf.m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_rom2: lat %0d data %h err %b want 3 cafef00d 0", lat, intf.m_rdata, intf.m_err);
    end
    do_txn(2, 1'b1, 32'h2008, 32'h5A5A1234, lat, dv);
    n_checks++;
    if (lat != 3 || dv !== 4'b0100 || intf.m_err !== 1'b0 || intf.m_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_ok: lat %0d done %b err %b data %h want 3 0100 0 0", lat, dv, intf.m_err, intf.m_rdata);
    end
    n_checks++;
    if (wsl_reg !== 32'h5A5A1234) begin
      n_fail++;
      $display("FAIL wr_data: got %h want 5a5a1234", wsl_reg);
    end
  endtask

  task automatic test_wrong_ack();
    setup(0, 1'b0, 32'h8000, 32'h0);
    intf.m_req[0] = 1'b1;
    repeat (3) @(negedge clk);
    inj_wr_ack = 1'b1;
    @(negedge clk);
    inj_wr_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (intf.m_done !== 4'h0) begin
      n_fail++;
      $display("FAIL wrong_ack: done %b want 0000", intf.m_done);
    end
    inj_rd_ack  = 1'b1;
    inj_rd_data = 32'h12345678;
    @(negedge clk);
    inj_rd_ack  = 1'b0;
    inj_rd_data = 32'h0;
    n_checks++;
    if (intf.m_done !== 4'b0001 || intf.m_rdata !== 32'h12345678 || intf.m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_after_wr_ack: done %b data %h err %b want 0001 12345678 0", intf.m_done, intf.m_rdata, intf.m_err);
    end
    intf.m_req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_issue_ack();
    setup(2, 1'b0, 32'h8000, 32'h0);
    intf.m_req[2] = 1'b1;
    @(negedge clk);
    inj_rd_ack  = 1'b1;
    inj_rd_data = 32'h0BADCAFE;
    @(negedge clk);
    inj_rd_ack  = 1'b0;
    inj_rd_data = 32'h0;
    n_checks++;
    if (intf.m_done !== 4'b0100 || intf.m_rdata !== 32'h0BADCAFE) begin
      n_fail++;
      $display("FAIL issue_ack: done %b data %h want 0100 0badcafe", intf.m_done, intf.m_rdata);
    end
    intf.m_req[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic saw1;
    setup(1, 1'b0, 32'h8000, 32'h0);
    setup(2, 1'b0, 32'h1010, 32'h0);
    intf.m_req[1] = 1'b1;
    repeat (2) @(negedge clk);
    intf.m_req[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    intf.m_req[1] = 1'b0;
    #1;
    n_checks++;
    if (intf.m_done !== 4'h0 || intf.m_rdata !== 32'h0 || intf.bus_addr !== 32'h0 || intf.m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: done %b data %h addr %h err %b want 0", intf.m_done, intf.m_rdata, intf.bus_addr, intf.m_err);
    end
    saw1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if (intf.m_done[1]) saw1 = 1'b1;
    n_checks++;
    if (intf.bus_rd_req !== 1'b1 || intf.bus_addr !== 32'h1010) begin
      n_fail++;
      $display("FAIL post_rst_c1: rd %b addr %h want 1 00001010", intf.bus_rd_req, intf.bus_addr);
    end
    @(negedge clk);
    if (intf.m_done[1]) saw1 = 1'b1;
    @(negedge clk);
    if (intf.m_done[1]) saw1 = 1'b1;
    n_checks++;
    if (intf.m_done !== 4'b0100 || intf.m_rdata !== 32'hCAFEF00D || saw1 !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_c3: done %b data %h aborted %b want 0100 cafef00d 0", intf.m_done, intf.m_rdata, saw1);
    end
    intf.m_req[2] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    intf.m_req   = '0;
    intf.m_we    = '0;
    intf.m_addr  = '0;
    intf.m_wdata = '0;
    test_reset();
    test_rom_read();
    test_arb_order();
    test_timeout();
    test_write();
    test_wrong_ack();
    test_issue_ack();
    test_reset_mid();
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
